// File: rtl/amm_burst_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : amm_pkg
// Description : Shared constants, state encoding and LFSR helper for the
//               Avalon-MM burst responder.
// Revision    : 1.0 - initial release
// ============================================================================
package amm_pkg;

  localparam int c_data_w  = 320;
  localparam int c_addr_w  = 25;
  localparam int c_burst_w = 7;
  localparam int c_mem_aw  = 10;
  localparam int c_rd_lat  = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } amm_state_e;

  // Plain-vector state codes used by the FSM registers
  localparam logic [1:0] c_st_idle = IDLE;
  localparam logic [1:0] c_st_wr   = WR_BURST;
  localparam logic [1:0] c_st_rd   = RD_BURST;

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form
  localparam logic [15:0] c_lfsr_seed = 16'hACE1;
  localparam logic [15:0] c_lfsr_taps = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & c_lfsr_taps)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/amm_burst_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : amm_burst_responder_if
// Description : Avalon-MM burst command/data bundle between a master
//               sequencer and the burst responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface amm_burst_responder_if
  import amm_pkg::*;
#(
  parameter int DATA_W  = c_data_w,
  parameter int ADDR_W  = c_addr_w,
  parameter int BURST_W = c_burst_w
);
  logic                  amm_ready;
  logic                  amm_read;
  logic                  amm_write;
  logic [ADDR_W-1:0]     amm_address;
  logic [BURST_W-1:0]    amm_burstcount;
  logic [DATA_W-1:0]     amm_writedata;
  logic [DATA_W/8-1:0]   amm_byteenable;
  logic [DATA_W-1:0]     amm_readdata;
  logic                  amm_readdatavalid;

  modport slave (
    output amm_ready, amm_readdata, amm_readdatavalid,
    input  amm_read, amm_write, amm_address, amm_burstcount,
           amm_writedata, amm_byteenable
  );

  modport master (
    input  amm_ready, amm_readdata, amm_readdatavalid,
    output amm_read, amm_write, amm_address, amm_burstcount,
           amm_writedata, amm_byteenable
  );
endinterface
`default_nettype wire

// File: rtl/amm_resp_ram.sv
`default_nettype none
// ============================================================================
// Module      : amm_resp_ram
// Description : Simple dual-port RAM, per-byte write enables, one-cycle
//               registered read. Contents are never cleared by reset.
// Revision    : 1.0 - initial release
// ============================================================================
module amm_resp_ram
  import amm_pkg::*;
#(
  parameter int DATA_W = c_data_w,
  parameter int AW     = c_mem_aw
) (
  input  wire logic                clk_i,
  input  wire logic                we_i,
  input  wire logic [AW-1:0]       waddr_i,
  input  wire logic [DATA_W-1:0]   wdata_i,
  input  wire logic [DATA_W/8-1:0] be_i,
  input  wire logic                re_i,
  input  wire logic [AW-1:0]       raddr_i,
  output logic      [DATA_W-1:0]   rdata_o
);
  localparam int c_nb = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [2**AW];
  logic [DATA_W-1:0] rdata_q;

  // Byte-lane gated write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < c_nb; b++) begin
        if (be_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  // Registered read port
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule
`default_nettype wire

// File: rtl/amm_burst_responder.sv
`default_nettype none
// ============================================================================
// Module      : amm_burst_responder
// Description : Avalon-MM burst slave backed by a byte-enabled RAM. Returns
//               fixed-latency (RD_LAT) contiguous read bursts.
//               Optional random backpressure: define AMM_RESP_STALL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module amm_burst_responder
  import amm_pkg::*;
#(
  parameter int DATA_W  = c_data_w,
  parameter int ADDR_W  = c_addr_w,
  parameter int BURST_W = c_burst_w,
  parameter int MEM_AW  = c_mem_aw,
  parameter int RD_LAT  = c_rd_lat
) (
  input  wire logic              emif_usr_clk,
  input  wire logic              emif_usr_reset_n,
  amm_burst_responder_if.slave   amm,
  output logic                   busy,
  output logic                   err,
  output logic [15:0]            wr_beats,
  output logic [15:0]            rd_beats
);
  logic [1:0]          state_q, state_d;
  logic [MEM_AW-1:0]   base_q, base_d;
  logic [BURST_W-1:0]  idx_q, idx_d, len_q, len_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic [15:0]         wr_cnt_q, rd_cnt_q;
  logic [RD_LAT-1:0]   vld_q;

  logic                w_wr_acc, w_issue, w_bc_zero, w_stall_nxt, w_rdv;
  logic [BURST_W-1:0]  w_cmd_len;
  logic [MEM_AW-1:0]   w_wr_addr, w_rd_addr;
  logic [DATA_W-1:0]   w_ram_rdata, w_last_dat;

  // ready is low in RD_BURST, so any accepted write is in IDLE or WR_BURST
  assign w_wr_acc  = ready_q & amm.amm_write;
  assign w_issue   = (state_q == c_st_rd);
  assign w_bc_zero = (amm.amm_burstcount == '0);
  assign w_cmd_len = w_bc_zero ? BURST_W'(1) : amm.amm_burstcount;
  assign w_rd_addr = base_q + MEM_AW'(idx_q);
  assign w_wr_addr = (state_q == c_st_idle) ? amm.amm_address[MEM_AW-1:0] : w_rd_addr;

  generate
    if (ADDR_W > MEM_AW) begin : g_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^amm.amm_address[ADDR_W-1:MEM_AW];
    end
  endgenerate

`ifdef AMM_RESP_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d      = lfsr_next(lfsr_q);
  // ready_q is registered from lfsr_d so it lines up with lfsr_q each cycle
  assign w_stall_nxt = (lfsr_d[1:0] == 2'b00);

  // Free-running backpressure LFSR
  always_ff @(posedge emif_usr_clk) begin
    if (!emif_usr_reset_n) lfsr_q <= c_lfsr_seed;
    else                   lfsr_q <= lfsr_d;
  end
`else
  assign w_stall_nxt = 1'b0;
`endif

  // Command/burst FSM next-state and error detection
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    idx_d   = idx_q;
    len_d   = len_q;
    err_d   = err_q;
    case (state_q)
      c_st_idle: begin
        if (ready_q && amm.amm_write) begin
          base_d = amm.amm_address[MEM_AW-1:0];
          len_d  = w_cmd_len;
          idx_d  = BURST_W'(1);
          if (w_bc_zero || amm.amm_read) err_d = 1'b1;
          if (w_cmd_len != BURST_W'(1)) state_d = c_st_wr;
        end else if (ready_q && amm.amm_read) begin
          base_d  = amm.amm_address[MEM_AW-1:0];
          len_d   = w_cmd_len;
          idx_d   = '0;
          if (w_bc_zero) err_d = 1'b1;
          state_d = c_st_rd;
        end
      end
      c_st_wr: begin
        if (ready_q && amm.amm_read) err_d = 1'b1;
        if (w_wr_acc) begin
          if (idx_q == len_q - BURST_W'(1)) state_d = c_st_idle;
          else                              idx_d   = idx_q + BURST_W'(1);
        end
      end
      c_st_rd: begin
        if (idx_q == len_q - BURST_W'(1)) state_d = c_st_idle;
        else                              idx_d   = idx_q + BURST_W'(1);
      end
      default: state_d = c_st_idle;
    endcase
    ready_d = (state_d != c_st_rd) & ~w_stall_nxt;
  end

  // Control state, read-valid pipeline and beat counters
  always_ff @(posedge emif_usr_clk) begin
    if (!emif_usr_reset_n) begin
      state_q  <= c_st_idle;
      base_q   <= '0;
      idx_q    <= '0;
      len_q    <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      vld_q    <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      wr_cnt_q <= wr_cnt_q + {15'd0, w_wr_acc};
      rd_cnt_q <= rd_cnt_q + {15'd0, w_rdv};
      vld_q[0] <= w_issue;
      for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  amm_resp_ram #(.DATA_W(DATA_W), .AW(MEM_AW)) u_ram (
    .clk_i   (emif_usr_clk),
    .we_i    (w_wr_acc),
    .waddr_i (w_wr_addr),
    .wdata_i (amm.amm_writedata),
    .be_i    (amm.amm_byteenable),
    .re_i    (w_issue),
    .raddr_i (w_rd_addr),
    .rdata_o (w_ram_rdata)
  );

  // The RAM register is the first latency stage; the rest are plain delays
  generate
    if (RD_LAT == 1) begin : g_lat1
      assign w_last_dat = w_ram_rdata;
    end else begin : g_latn
      logic [DATA_W-1:0] dat_q [RD_LAT-1];
      // Data shift stages; validity travels separately in vld_q
      always_ff @(posedge emif_usr_clk) begin
        dat_q[0] <= w_ram_rdata;
        for (int i = 1; i < RD_LAT - 1; i++) dat_q[i] <= dat_q[i-1];
      end
      assign w_last_dat = dat_q[RD_LAT-2];
    end
  endgenerate

  assign w_rdv                 = vld_q[RD_LAT-1];
  assign amm.amm_readdatavalid = w_rdv;
  // Gated so stale/unreset data never shows on the bus
  assign amm.amm_readdata      = w_rdv ? w_last_dat : '0;
  assign amm.amm_ready         = ready_q;
  assign busy                  = (state_q != c_st_idle) | (|vld_q);
  assign err                   = err_q;
  assign wr_beats              = wr_cnt_q;
  assign rd_beats              = rd_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_amm_burst_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_amm_burst_responder
// Description : Self-checking bench: vector table, directed corner cases and
//               randomized bursts against a byte-level memory model with a
//               timed read-beat scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_amm_burst_responder;
  import amm_pkg::*;

  localparam int DATA_W  = 320;
  localparam int ADDR_W  = 25;
  localparam int BURST_W = 7;
  localparam int MEM_AW  = 10;
  localparam int RD_LAT  = 2;
  localparam int NB      = DATA_W / 8;
  localparam int DEPTH   = 1 << MEM_AW;
  localparam logic [NB-1:0] BE_ALL = '1;
  localparam logic [NB-1:0] BE_B0  = NB'(1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, err;
  logic [15:0] wr_beats, rd_beats;

  amm_burst_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W)) amm ();

  amm_burst_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W), .MEM_AW(MEM_AW), .RD_LAT(RD_LAT)
  ) dut (
    .emif_usr_clk     (clk),
    .emif_usr_reset_n (rst_n),
    .amm              (amm),
    .busy             (busy),
    .err              (err),
    .wr_beats         (wr_beats),
    .rd_beats         (rd_beats)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
    logic [NB-1:0]     kn;
  } beat_t;

  typedef struct {
    bit            is_wr;
    int            addr;
    int            bc;
    logic [NB-1:0] be;
    logic [7:0]    pat;
    int            exp_wr;
    int            exp_rd;
  } vec_t;

  beat_t             exp_q[$];
  logic [DATA_W-1:0] mem  [DEPTH];
  logic [NB-1:0]     mkn  [DEPTH];
  int cyc = 0, errors = 0, checks = 0, exp_wr = 0, exp_rd = 0;
  bit exp_err = 1'b0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask

  function automatic logic [DATA_W-1:0] bytemask(input logic [NB-1:0] k);
    logic [DATA_W-1:0] m;
    for (int b = 0; b < NB; b++) m[b*8 +: 8] = {8{k[b]}};
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    for (int w = 0; w < DATA_W / 32; w++) d[w*32 +: 32] = $urandom();
    return d;
  endfunction

  // Scoreboard: every due beat must appear exactly in its cycle, nothing else
  always @(posedge clk) begin : mon
    beat_t e;
    logic [DATA_W-1:0] m;
    cyc = cyc + 1;
    #1;
    if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      m = bytemask(e.kn);
      chk("rdv_beat", DATA_W'(amm.amm_readdatavalid), DATA_W'(1));
      chk("rdata", amm.amm_readdata & m, e.data & m);
      exp_rd++;
    end else if (amm.amm_readdatavalid !== 1'b0) begin
      chk("rdv_unexpected", DATA_W'(amm.amm_readdatavalid), '0);
    end
  end

  task automatic idle_inputs();
    amm.amm_read = 1'b0; amm.amm_write = 1'b0; amm.amm_address = '0;
    amm.amm_burstcount = '0; amm.amm_writedata = '0; amm.amm_byteenable = '0;
  endtask

  task automatic wait_ready(input string what);
    int n = 0;
    while (amm.amm_ready !== 1'b1) begin
      if (n >= 200) begin
        chk({what, "_ready_timeout"}, '0, DATA_W'(1));
        return;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wr_burst(input int addr, input int bc, input logic [NB-1:0] be, input bit rnd,
                          input logic [7:0] pat, input int gap_at, input int gap_n,
                          input bit x_after, input bit with_read);
    int len = (bc == 0) ? 1 : bc;
    int a;
    logic [DATA_W-1:0] d;
    if (bc == 0 || with_read) exp_err = 1'b1;
    for (int k = 0; k < len; k++) begin
      if (k == gap_at && gap_n > 0) begin
        amm.amm_write = 1'b0;
        repeat (gap_n) @(negedge clk);
      end
      d = rnd ? rand_data() : {NB{8'(pat + 8'(k))}};
      amm.amm_write = 1'b1;
      amm.amm_read = with_read && (k == 0);
      amm.amm_writedata = d;
      amm.amm_byteenable = be;
      if (k == 0) begin
        amm.amm_address = ADDR_W'(addr);
        amm.amm_burstcount = BURST_W'(bc);
      end else if (x_after) begin
        amm.amm_address = 'x;
        amm.amm_burstcount = 'x;
      end
      wait_ready("wr");
      a = (addr + k) & (DEPTH - 1);
      for (int b = 0; b < NB; b++) begin
        if (be[b]) begin
          mem[a][b*8 +: 8] = d[b*8 +: 8];
          mkn[a][b] = 1'b1;
        end
      end
      exp_wr++;
      @(negedge clk);
    end
    amm.amm_write = 1'b0;
    amm.amm_read = 1'b0;
  endtask

  task automatic rd_burst(input int addr, input int bc);
    int len = (bc == 0) ? 1 : bc;
    int t, a;
    if (bc == 0) exp_err = 1'b1;
    amm.amm_read = 1'b1;
    amm.amm_address = ADDR_W'(addr);
    amm.amm_burstcount = BURST_W'(bc);
    wait_ready("rd");
    t = cyc + 1;
    for (int k = 0; k < len; k++) begin
      a = (addr + k) & (DEPTH - 1);
      exp_q.push_back('{due: t + RD_LAT + k, data: mem[a], kn: mkn[a]});
    end
    @(negedge clk);
    amm.amm_read = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      chk({tag, "_drain_timeout"}, DATA_W'(exp_q.size()), '0);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
    chk({tag, "_busy"}, DATA_W'(busy), '0);
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_wr_beats"}, DATA_W'(wr_beats), DATA_W'(16'(exp_wr)));
    chk({tag, "_rd_beats"}, DATA_W'(rd_beats), DATA_W'(16'(exp_rd)));
    chk({tag, "_err"}, DATA_W'(err), DATA_W'(exp_err));
  endtask

  task automatic chk_reset_outputs(input string tag, input bit ready_exp);
    chk({tag, "_ready"}, DATA_W'(amm.amm_ready), DATA_W'(ready_exp));
    chk({tag, "_rdv"}, DATA_W'(amm.amm_readdatavalid), '0);
    chk({tag, "_rdata"}, amm.amm_readdata, '0);
    chk({tag, "_busy"}, DATA_W'(busy), '0);
    chk({tag, "_err"}, DATA_W'(err), '0);
    chk({tag, "_wr_beats"}, DATA_W'(wr_beats), '0);
    chk({tag, "_rd_beats"}, DATA_W'(rd_beats), '0);
  endtask

  vec_t tbl [7];

  initial begin
    int addr, lo, len, last_wr;
    tbl[0] = '{1, 0,          6, BE_ALL, 8'h00, 6,  0};
    tbl[1] = '{1, 6,          6, BE_ALL, 8'h06, 12, 0};
    tbl[2] = '{0, 0,          6, BE_ALL, 8'h00, 12, 6};
    tbl[3] = '{0, 6,          6, BE_ALL, 8'h00, 12, 12};
    tbl[4] = '{1, DEPTH - 2,  2, BE_ALL, 8'hA0, 14, 12};
    tbl[5] = '{1, DEPTH - 2,  4, BE_B0,  8'h50, 18, 12};
    tbl[6] = '{0, DEPTH - 2,  4, BE_ALL, 8'h00, 18, 16};
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
      mkn[i] = '0;
    end

    // Reset held three edges, then released
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("in_reset", 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("after_release", 1'b1);

    // Vector table: sequential bursts, wrap-around and single-lane writes
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].is_wr) wr_burst(tbl[i].addr, tbl[i].bc, tbl[i].be, 1'b0, tbl[i].pat, -1, 0, 1'b0, 1'b0);
      else              rd_burst(tbl[i].addr, tbl[i].bc);
      drain($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_wr_beats", i), DATA_W'(wr_beats), DATA_W'(16'(tbl[i].exp_wr)));
      chk($sformatf("vec%0d_rd_beats", i), DATA_W'(rd_beats), DATA_W'(16'(tbl[i].exp_rd)));
      chk($sformatf("vec%0d_err", i), DATA_W'(err), '0);
    end

    // Write wait states mid-burst with address/burstcount undriven after beat 0
    wr_burst(100, 6, BE_ALL, 1'b0, 8'h30, 3, 3, 1'b1, 1'b0);
    rd_burst(100, 6);
    drain("gap");
    chk_status("gap");

    // read+write together, then zero burstcount on write and read
    wr_burst(200, 1, BE_ALL, 1'b0, 8'h77, -1, 0, 1'b0, 1'b1);
    drain("rw_both");
    chk_status("rw_both");
    wr_burst(201, 0, BE_ALL, 1'b0, 8'h78, -1, 0, 1'b0, 1'b0);
    drain("bc0_wr");
    chk_status("bc0_wr");
    rd_burst(200, 0);
    drain("bc0_rd");
    rd_burst(200, 2);
    drain("rw_readback");
    chk_status("err_sticky");

    // Reset in the middle of a read burst
    wr_burst(300, 6, BE_ALL, 1'b0, 8'h90, -1, 0, 1'b0, 1'b0);
    drain("pre_rst");
    rd_burst(300, 6);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    idle_inputs();
    repeat (2) @(negedge clk);
    exp_wr = 0; exp_rd = 0; exp_err = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("mid_rst", 1'b1);
    rd_burst(300, 6);
    drain("post_rst");
    chk_status("post_rst");

    // Randomized bursts, overlapping read pipelines, upper address bits noise
    last_wr = 0;
    for (int i = 0; i < 60; i++) begin
      lo   = $urandom_range(0, 1) ? $urandom_range(DEPTH - 8, DEPTH - 1) : $urandom_range(0, 40);
      addr = ($urandom() & ((1 << ADDR_W) - 1) & ~(DEPTH - 1)) | lo;
      len  = $urandom_range(1, 8);
      case ($urandom_range(0, 3))
        0: rd_burst(addr, len);
        1: rd_burst(last_wr, len);
        default: begin
          wr_burst(addr, len, NB'({$urandom(), $urandom()}), 1'b1, 8'h00,
                   $urandom_range(1, 8), $urandom_range(0, 2), 1'b0, 1'b0);
          last_wr = addr;
        end
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain("rand");
    chk_status("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
